// File: rtl/ram_arbiter_if.sv
// Bus bundle for ram_arbiter: write buffer port, read port, fill command
// and the single-port RAM interface.
interface ram_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 4
);
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          clr_start;
    logic [DW-1:0] clr_val;
    logic          busy;
    logic          clr_done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_d;
    logic          ram_we;
    logic [DW-1:0] ram_q;

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_req, rd_addr, clr_start, clr_val, ram_q,
        output wr_ready, rd_ack, rd_valid, rd_data, busy, clr_done, ram_addr, ram_d, ram_we
    );

    modport master (
        output wr_valid, wr_addr, wr_data, rd_req, rd_addr, clr_start, clr_val, ram_q,
        input  wr_ready, rd_ack, rd_valid, rd_data, busy, clr_done, ram_addr, ram_d, ram_we
    );
endinterface

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: buffered writes, starvation-bounded read priority,
// and a drain-then-fill memory clear sweep.
module ram_arbiter #(
    parameter int AW     = 12,
    parameter int DW     = 4,
    parameter int WBUF   = 4,
    parameter int STARVE = 8,
    parameter int RD_LAT = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    ram_arbiter_if.slave bus
);
    localparam int PW = $clog2(WBUF);
    localparam int SW = $clog2(STARVE + 1);

    typedef enum logic [1:0] {ARB = 2'd0, DRAIN = 2'd1, CLEAR = 2'd2} state_t;

    state_t        state_r, state_s;
    logic [AW-1:0] fifo_addr_r [WBUF];
    logic [DW-1:0] fifo_data_r [WBUF];
    logic [PW:0]   wptr_r, rptr_r, count_s;
    logic          empty_s, full_s, push_s;
    logic          rd_grant_s, wr_grant_s, clr_wr_s;
    logic [SW-1:0] starve_r;
    logic [AW-1:0] clr_addr_r;
    logic [DW-1:0] clr_val_r;
    logic          clr_done_r;
    logic [RD_LAT:0] rd_pipe_r;
    logic          ram_we_r;
    logic [AW-1:0] ram_addr_r;
    logic [DW-1:0] ram_d_r;

    assign count_s = wptr_r - rptr_r;
    assign empty_s = (count_s == {(PW+1){1'b0}});
    assign full_s  = (count_s == (PW+1)'(WBUF));
    assign push_s  = bus.wr_valid && bus.wr_ready;

    assign bus.wr_ready = (state_r == ARB) && !full_s;
    assign bus.rd_ack   = rd_grant_s;
    assign bus.busy     = (state_r != ARB);
    assign bus.clr_done = clr_done_r;
    assign bus.rd_valid = rd_pipe_r[RD_LAT];
    assign bus.rd_data  = rd_pipe_r[RD_LAT] ? bus.ram_q : {DW{1'b0}};
    assign bus.ram_addr = ram_addr_r;
    assign bus.ram_d    = ram_d_r;
    assign bus.ram_we   = ram_we_r;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ARB;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state: DRAIN leaves once empty; CLEAR holds one extra cycle for clr_done
    always_comb begin
        state_s = state_r;
        case (state_r)
            ARB: begin
                if (bus.clr_start) state_s = DRAIN;
                else               state_s = ARB;
            end
            DRAIN: begin
                if (empty_s) state_s = CLEAR;
                else         state_s = DRAIN;
            end
            CLEAR: begin
                if (clr_done_r) state_s = ARB;
                else            state_s = CLEAR;
            end
            default: state_s = ARB;
        endcase
    end

    // Grant decode: at most one RAM operation per cycle
    always_comb begin
        rd_grant_s = 1'b0;
        wr_grant_s = 1'b0;
        clr_wr_s   = 1'b0;
        case (state_r)
            ARB: begin
                if (bus.rd_req && (starve_r < SW'(STARVE))) rd_grant_s = 1'b1;
                else if (!empty_s)                          wr_grant_s = 1'b1;
                else                                        wr_grant_s = 1'b0;
            end
            DRAIN: begin
                if (!empty_s) wr_grant_s = 1'b1;
                else          wr_grant_s = 1'b0;
            end
            CLEAR: begin
                if (!clr_done_r) clr_wr_s = 1'b1;
                else             clr_wr_s = 1'b0;
            end
            default: begin
                rd_grant_s = 1'b0;
                wr_grant_s = 1'b0;
                clr_wr_s   = 1'b0;
            end
        endcase
    end

    // Write-buffer pointers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_r <= {(PW+1){1'b0}};
            rptr_r <= {(PW+1){1'b0}};
        end else begin
            if (push_s)     wptr_r <= wptr_r + (PW+1)'(1);
            if (wr_grant_s) rptr_r <= rptr_r + (PW+1)'(1);
        end
    end

    // Write-buffer storage (contents are don't-care while empty)
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_addr_r[wptr_r[PW-1:0]] <= bus.wr_addr;
            fifo_data_r[wptr_r[PW-1:0]] <= bus.wr_data;
        end
    end

    // Starvation counter: reads granted back-to-back while a write waits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_r <= {SW{1'b0}};
        end else if (wr_grant_s || empty_s) begin
            starve_r <= {SW{1'b0}};
        end else if (rd_grant_s && (starve_r < SW'(STARVE))) begin
            starve_r <= starve_r + SW'(1);
        end else begin
            starve_r <= starve_r;
        end
    end

    // Clear sweep address, captured fill value and completion pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_addr_r <= {AW{1'b0}};
            clr_val_r  <= {DW{1'b0}};
            clr_done_r <= 1'b0;
        end else begin
            if ((state_r == ARB) && bus.clr_start) clr_val_r <= bus.clr_val;
            if (state_r != CLEAR)  clr_addr_r <= {AW{1'b0}};
            else if (clr_wr_s)     clr_addr_r <= clr_addr_r + AW'(1);
            clr_done_r <= clr_wr_s && (clr_addr_r == {AW{1'b1}});
        end
    end

    // Registered RAM port; address/data hold when idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_we_r   <= 1'b0;
            ram_addr_r <= {AW{1'b0}};
            ram_d_r    <= {DW{1'b0}};
        end else if (clr_wr_s) begin
            ram_we_r   <= 1'b1;
            ram_addr_r <= clr_addr_r;
            ram_d_r    <= clr_val_r;
        end else if (wr_grant_s) begin
            ram_we_r   <= 1'b1;
            ram_addr_r <= fifo_addr_r[rptr_r[PW-1:0]];
            ram_d_r    <= fifo_data_r[rptr_r[PW-1:0]];
        end else if (rd_grant_s) begin
            ram_we_r   <= 1'b0;
            ram_addr_r <= bus.rd_addr;
        end else begin
            ram_we_r   <= 1'b0;
        end
    end

    // Read return pipeline: one port-register stage plus RAM latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pipe_r <= {(RD_LAT+1){1'b0}};
        end else begin
            rd_pipe_r <= {rd_pipe_r[RD_LAT-1:0], rd_grant_s};
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Randomised and directed bench for ram_arbiter with a queue-based reference
// model, a behavioural RAM, and a scoreboard monitor for RAM writes and reads.
module tb_ram_arbiter;
    localparam int AW = 12, DW = 4, WBUF = 4, STARVE = 8, RD_LAT = 2;
    localparam int NWORDS = 1 << AW;
    localparam int M_ARB = 0, M_DRAIN = 1, M_CLEAR = 2;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    typedef struct { logic [DW-1:0] d; int cyc; } rd_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0, failures = 0, cyc = 0, done_cnt = 0;

    ram_arbiter_if #(.AW(AW), .DW(DW)) bus();

    ram_arbiter #(.AW(AW), .DW(DW), .WBUF(WBUF), .STARVE(STARVE), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM with RD_LAT read latency
    logic [DW-1:0] ram_mem [NWORDS];
    logic [DW-1:0] q_pipe [RD_LAT];
    always @(posedge clk) begin
        if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_d;
        q_pipe[0] <= ram_mem[bus.ram_addr];
        for (int k = 1; k < RD_LAT; k++) q_pipe[k] <= q_pipe[k-1];
    end
    assign bus.ram_q = q_pipe[RD_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state
    logic [DW-1:0] mem_m [NWORDS];
    wr_t fq[$];
    wr_t wq[$];
    rd_t rq[$];
    wr_t pend, mw;
    bit  pend_v = 1'b0, rd_g, wr_g, exp_ready, exp_done, ack_seen = 1'b0, wacc_seen = 1'b0;
    int  mode = M_ARB, starve = 0, clr_next = 0, occ;
    logic [DW-1:0] clr_val_m;

    // Model step: predicts this cycle's grants from the arbitration rules
    always @(negedge clk) begin
        if (!reset_n) begin
            fq.delete(); wq.delete(); rq.delete();
            pend_v = 1'b0; mode = M_ARB; starve = 0; ack_seen = 1'b0; wacc_seen = 1'b0;
        end else begin
            if (pend_v) begin mem_m[pend.a] = pend.d; pend_v = 1'b0; end
            occ = fq.size();
            exp_ready = (mode == M_ARB) && (occ < WBUF);
            exp_done = 1'b0; rd_g = 1'b0; wr_g = 1'b0;
            case (mode)
                M_ARB: begin
                    rd_g = bus.rd_req && (starve < STARVE);
                    if (!rd_g && occ > 0) begin wr_g = 1'b1; mw = fq.pop_front(); end
                end
                M_DRAIN: if (occ > 0) begin wr_g = 1'b1; mw = fq.pop_front(); end
                M_CLEAR: begin
                    if (clr_next < NWORDS) begin
                        mw.a = AW'(clr_next); mw.d = clr_val_m; wr_g = 1'b1; clr_next++;
                    end else exp_done = 1'b1;
                end
                default: ;
            endcase
            chk("rd_ack", 32'(bus.rd_ack), 32'(rd_g));
            chk("wr_ready", 32'(bus.wr_ready), 32'(exp_ready));
            chk("busy", 32'(bus.busy), 32'(mode != M_ARB));
            chk("clr_done", 32'(bus.clr_done), 32'(exp_done));
            if (bus.clr_done) done_cnt++;
            if (wr_g || occ == 0) starve = 0;
            else if (rd_g && starve < STARVE) starve++;
            if (rd_g) rq.push_back('{mem_m[bus.rd_addr], cyc + 1 + RD_LAT});
            if (wr_g) begin wq.push_back(mw); pend = mw; pend_v = 1'b1; end
            if (bus.wr_valid && exp_ready) fq.push_back('{bus.wr_addr, bus.wr_data});
            ack_seen  = bus.rd_ack;
            wacc_seen = bus.wr_valid && bus.wr_ready;
            case (mode)
                M_ARB:   if (bus.clr_start) begin mode = M_DRAIN; clr_val_m = bus.clr_val; end
                M_DRAIN: if (occ == 0) begin mode = M_CLEAR; clr_next = 0; end
                M_CLEAR: if (exp_done) mode = M_ARB;
                default: mode = M_ARB;
            endcase
        end
    end

    // Scoreboard monitor: compares RAM writes and read returns as they appear
    wr_t ew;
    rd_t er;
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.ram_we) begin
                if (wq.size() == 0) chk("ram_we_unexpected", 32'(1), 32'(0));
                else begin
                    ew = wq.pop_front();
                    chk("ram_addr", 32'(bus.ram_addr), 32'(ew.a));
                    chk("ram_d", 32'(bus.ram_d), 32'(ew.d));
                end
            end
            if (bus.rd_valid) begin
                if (rq.size() == 0) chk("rd_valid_unexpected", 32'(1), 32'(0));
                else begin
                    er = rq.pop_front();
                    chk("rd_data", 32'(bus.rd_data), 32'(er.d));
                    chk("rd_latency", 32'(cyc), 32'(er.cyc));
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok = 1'b0;
        bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        for (int t = 0; t < 64 && !ok; t++) begin next_cycle(); ok = wacc_seen; end
        if (!ok) chk("wr_accept_timeout", 32'(0), 32'(1));
        bus.wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        bit ok = 1'b0;
        bus.rd_req = 1'b1; bus.rd_addr = a;
        for (int t = 0; t < 64 && !ok; t++) begin next_cycle(); ok = ack_seen; end
        if (!ok) chk("rd_ack_timeout", 32'(0), 32'(1));
        bus.rd_req = 1'b0;
    endtask

    task automatic wait_arb(input int limit);
        bit ok = 1'b0;
        for (int t = 0; t < limit && !ok; t++) begin next_cycle(); ok = (mode == M_ARB); end
        if (!ok) chk("clear_timeout", 32'(0), 32'(1));
    endtask

    task automatic rand_cycles(input int n, input int wr_pct, input int rd_pct);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            if (bus.wr_valid && wacc_seen) bus.wr_valid = 1'b0;
            if (!bus.wr_valid && $urandom_range(99) < wr_pct) begin
                bus.wr_valid = 1'b1;
                bus.wr_addr  = AW'($urandom_range(15));
                bus.wr_data  = DW'($urandom);
            end
            if (bus.rd_req && ack_seen) bus.rd_req = 1'b0;
            if (!bus.rd_req && $urandom_range(99) < rd_pct) begin
                bus.rd_req  = 1'b1;
                bus.rd_addr = AW'($urandom_range(15));
            end
        end
        while (bus.wr_valid && !wacc_seen) next_cycle();
        bus.wr_valid = 1'b0;
        while (bus.rd_req && !ack_seen) next_cycle();
        bus.rd_req = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_ram_we", 32'(bus.ram_we), 32'(0));
        chk("rst_ram_addr", 32'(bus.ram_addr), 32'(0));
        chk("rst_ram_d", 32'(bus.ram_d), 32'(0));
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'(0));
        chk("rst_rd_data", 32'(bus.rd_data), 32'(0));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_clr_done", 32'(bus.clr_done), 32'(0));
    endtask

    int done_before;

    initial begin
        for (int i = 0; i < NWORDS; i++) begin
            ram_mem[i] <= DW'(i * 3);
            mem_m[i]    = DW'(i * 3);
        end
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_req = 1'b0; bus.rd_addr = '0; bus.clr_start = 1'b0; bus.clr_val = '0;
        #12;
        check_reset_outputs();
        next_cycle();
        reset_n = 1'b1;
        idle(2);

        // Write then read back the same address
        do_write(12'h123, 4'hA);
        idle(3);
        do_read(12'h123);
        idle(6);

        // Held reads with five writes: buffer fills, starvation lets writes through
        bus.rd_req = 1'b1; bus.rd_addr = 12'h010;
        for (int i = 0; i < 5; i++) do_write(AW'(12'h200 + i), DW'(i + 1));
        idle(40);
        bus.rd_req = 1'b0;
        idle(6);

        // One buffered write under continuous reads
        bus.rd_req = 1'b1; bus.rd_addr = 12'h020;
        do_write(12'h300, 4'h7);
        idle(20);
        bus.rd_req = 1'b0;
        idle(4);

        // Read of an address still pending in the buffer, then after it drains
        bus.rd_req = 1'b1; bus.rd_addr = 12'h055;
        do_write(12'h055, 4'hC);
        bus.rd_req = 1'b0;
        idle(4);
        do_read(12'h055);
        idle(6);

        rand_cycles(1500, 40, 50);
        idle(8);

        // Clear with two buffered writes; reads and a second clr_start are ignored
        done_before = done_cnt;
        bus.rd_req = 1'b1; bus.rd_addr = 12'h001;
        do_write(12'h0A0, 4'h3);
        do_write(12'h0A1, 4'h4);
        bus.clr_start = 1'b1; bus.clr_val = 4'h5;
        next_cycle();
        bus.clr_start = 1'b0;
        idle(100);
        bus.clr_start = 1'b1; bus.clr_val = 4'h9;
        next_cycle();
        bus.clr_start = 1'b0;
        wait_arb(5000);
        while (bus.rd_req && !ack_seen) next_cycle();
        bus.rd_req = 1'b0;
        chk("clr_done_count", 32'(done_cnt - done_before), 32'(1));
        idle(4);
        do_read(12'h0A0);
        do_read(12'hFFF);
        idle(6);

        rand_cycles(600, 40, 50);
        idle(8);

        // Reset in the middle of a clear sweep
        done_before = done_cnt;
        bus.clr_start = 1'b1; bus.clr_val = 4'hE;
        next_cycle();
        bus.clr_start = 1'b0;
        for (int t = 0; t < 5000 && !(mode == M_CLEAR && clr_next >= 12'h800); t++) next_cycle();
        chk("reached_clear_0x800", 32'(mode == M_CLEAR && clr_next >= 12'h800), 32'(1));
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        idle(2);
        reset_n = 1'b1;
        idle(20);
        chk("aborted_clr_done", 32'(done_cnt - done_before), 32'(0));
        do_read(12'h7FF);
        do_read(12'h900);
        idle(6);

        rand_cycles(600, 40, 50);
        idle(12);
        chk("write_queue_drained", 32'(wq.size()), 32'(0));
        chk("read_queue_drained", 32'(rq.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
